// File: rtl/kbd_ctrl.sv
// PS/2 keyboard receiver with a 16-entry scancode FIFO behind a two-register read window.
// Latency: a byte is readable one cycle after the filtered stop-bit sample; reads are combinational.
// Backpressure: none toward the keyboard; a full FIFO drops new bytes and sets sticky ovf.
module kbd_ctrl #(
    parameter int FIFO_AW    = 4,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        rd,
    input  logic        addr,
    output logic [31:0] data_out,
    output logic        irq
);

    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [FW-1:0]      FMAX    = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]      TMAX    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]      TONE    = TW'(1);
    localparam logic [FW-1:0]      FONE    = FW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic              clk_s1, clk_s2, dat_s1, dat_s2;
    logic              filt_clk;
    logic [FW-1:0]     filt_cnt;
    logic              fall;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic              par_bit;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit;
    logic              frame_ok;
    logic              push;
    logic              perr_set;

    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]  count;
    logic              ovf, perr;
    logic              full, pop, stat_rd, do_push;
    logic [4:0]        cnt5;

    // Two-flop synchronizers for both raw PS/2 lines; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after the synchronized clock holds the opposite level FILTER_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FMAX) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FONE;
        end
    end

    // The cycle in which the filtered clock goes 1->0 is the sample event; data is taken alongside it.
    assign fall     = filt_clk && !clk_s2 && (filt_cnt == FMAX);
    assign tmo_hit  = (state != IDLE) && !fall && (tmo_cnt == TMAX);
    assign frame_ok = dat_s2 && (^{shift_q, par_bit});
    assign push     = fall && (state == STOP) && frame_ok;
    assign perr_set = (fall && (state == STOP) && !frame_ok) || tmo_hit;

    // Frame decoder: start, 8 data bits LSB first, odd parity, stop; stalls abort after TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else if (tmo_hit) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE || fall) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + TONE;
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_q <= {dat_s2, shift_q[7:1]};
                        if (bit_cnt == 3'd7) state <= PARITY;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign full    = (count == CNT_FULL);
    assign pop     = sel && rd && !addr && (count != '0);
    assign stat_rd = sel && rd && addr;
    // On a full FIFO a push is only accepted when a pop frees the head slot at the same edge.
    assign do_push = push && (!full || pop);

    // FIFO storage; the write slot is never the one being read unless that slot is popped this edge.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_q;
    end

    // FIFO pointers, occupancy and sticky status flags (a new set beats a clearing status read).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            perr   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !pop)      count <= count + CNT_ONE;
            else if (!do_push && pop) count <= count - CNT_ONE;

            if (push && full && !pop) ovf <= 1'b1;
            else if (stat_rd)         ovf <= 1'b0;

            if (perr_set)     perr <= 1'b1;
            else if (stat_rd) perr <= 1'b0;
        end
    end

    assign cnt5 = 5'(count);
    assign irq  = (count != '0);

    // Read mux: DATA shows the head byte with a valid flag, STATUS shows count and sticky flags.
    always_comb begin
        data_out = 32'h0;
        if (sel) begin
            if (addr)             data_out = {16'd0, 3'd0, cnt5, 6'd0, ovf, perr};
            else if (count != '0) data_out = {23'd0, 1'b1, mem[rd_ptr]};
        end
    end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Bench for kbd_ctrl: table of PS/2 frames and register reads, plus hand-written overflow,
// glitch/timeout and mid-frame reset sequences. DATA reads are checked against a queue of
// bytes pushed when each good frame is sent.
module tb_kbd_ctrl;

    localparam int FL  = 8;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk, ps2_data, sel, rd, addr;
    logic [31:0] data_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb [$];

    kbd_ctrl #(.FIFO_AW(4), .FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .sel(sel), .rd(rd), .addr(addr), .data_out(data_out), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {OP_SEND, OP_BAD, OP_RDDATA, OP_RDSTAT, OP_IRQ, OP_SELLOW} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  val;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (14) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        if (!bad && sb.size() < 16) sb.push_back({23'd0, 1'b1, b});
    endtask

    task automatic do_read(input logic a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; rd = 1'b1;
        #2 d = data_out;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0; addr = 1'b0;
    endtask

    task automatic rd_data(input string name);
        logic [31:0] d, e;
        do_read(1'b0, d);
        e = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        check(name, d, e);
    endtask

    task automatic rd_stat(input string name, input logic [31:0] e);
        logic [31:0] d;
        do_read(1'b1, d);
        check(name, d, e);
    endtask

    task automatic add(input op_t op, input logic [7:0] v, input logic [31:0] e);
        vec_t t;
        t.op = op; t.val = v; t.exp = e;
        vecs.push_back(t);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        sel = 1'b0; rd = 1'b0; addr = 1'b0;

        // single byte, then two back-to-back, then a parity error
        add(OP_SEND,   8'h1C, 32'h0);
        add(OP_IRQ,    8'h00, 32'h1);
        add(OP_SELLOW, 8'h00, 32'h0);
        add(OP_RDDATA, 8'h00, 32'h0);
        add(OP_RDDATA, 8'h00, 32'h0);
        add(OP_IRQ,    8'h00, 32'h0);
        add(OP_SEND,   8'hF0, 32'h0);
        add(OP_SEND,   8'h1C, 32'h0);
        add(OP_RDSTAT, 8'h00, 32'h0000_0200);
        add(OP_RDDATA, 8'h00, 32'h0);
        add(OP_RDSTAT, 8'h00, 32'h0000_0100);
        add(OP_RDDATA, 8'h00, 32'h0);
        add(OP_RDSTAT, 8'h00, 32'h0000_0000);
        add(OP_BAD,    8'h1C, 32'h0);
        add(OP_RDSTAT, 8'h00, 32'h0000_0001);
        add(OP_RDSTAT, 8'h00, 32'h0000_0000);

        repeat (2) @(negedge clk);
        sel = 1'b1; addr = 1'b1;
        #1 check("reset_status", data_out, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        sel = 1'b0; addr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_SEND:   send_frame(vecs[i].val, 1'b0);
                OP_BAD:    send_frame(vecs[i].val, 1'b1);
                OP_RDDATA: rd_data($sformatf("vec%0d_data", i));
                OP_RDSTAT: rd_stat($sformatf("vec%0d_status", i), vecs[i].exp);
                OP_IRQ: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_irq", i), {31'd0, irq}, vecs[i].exp);
                end
                OP_SELLOW: begin
                    @(negedge clk);
                    sel = 1'b0; addr = 1'b0;
                    #1 check($sformatf("vec%0d_sel_low", i), data_out, 32'h0);
                end
                default: ;
            endcase
        end

        // overflow: 17 frames, no reads
        for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i), 1'b0);
        rd_stat("ovf_status", 32'h0000_1002);
        for (int i = 0; i < 16; i++) rd_data($sformatf("ovf_data%0d", i));
        rd_stat("ovf_drained", 32'h0);

        // glitch on ps2_clk while idle must be ignored
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        rd_stat("glitch_status", 32'h0);

        // partial frame then stall -> timeout abort with perr
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TMO + 1) @(negedge clk);
        rd_stat("timeout_status", 32'h0000_0001);
        send_frame(8'h33, 1'b0);
        rd_data("after_timeout_data");

        // reset in the middle of the data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b0);
        rd_data("after_reset_data");
        rd_stat("after_reset_status", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_ctrl.md
KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 Parameter FIFO_AW, default 4, log2 of scancode FIFO depth (16 entries).
REQ-002 Parameter FILTER_LEN, default 8, clk cycles a synchronized ps2_clk level must hold before the filtered clock accepts it.
REQ-003 Parameter TIMEOUT, default 20000, clk cycles without a filtered falling edge before a partial frame is aborted.
REQ-004 clk  input  1  system clock; all state on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-008 sel  input  1  access targets the keyboard window (dmem_addr[29:26]==4'he).
REQ-009 rd  input  1  single-cycle read strobe, qualified by sel.
REQ-010 addr  input  1  register select: 0 = DATA, 1 = STATUS.
REQ-011 data_out  output  32  combinational read data.
REQ-012 irq  output  1  high while the FIFO is non-empty.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-014 Filtered clock SHALL change only after the synchronized ps2_clk holds the opposite level for FILTER_LEN consecutive cycles; a filtered 1->0 transition is a sample event.
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP; one transition per sample event.
REQ-016 IDLE: sample 0 -> DATA, bit counter 0; sample 1 -> stay IDLE (no error).
REQ-017 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: store bit -> STOP; frame parity is odd over 8 data bits plus parity bit.
REQ-019 STOP: stop bit 1 and odd parity -> push byte, -> IDLE; otherwise set sticky perr, no push, -> IDLE.
REQ-020 Any state other than IDLE with no sample event for TIMEOUT cycles SHALL return to IDLE, discard the partial byte, and set sticky perr.
REQ-021 Push occurs in the same cycle as the STOP sample event; byte is readable on the following cycle.
REQ-022 DATA read (addr=0) returns {23'd0, valid, head_byte}; valid = FIFO non-empty; empty FIFO returns 32'h0.
REQ-023 rd with sel and addr=0 on a non-empty FIFO SHALL pop exactly one entry at that clock edge; read on empty pops nothing.
REQ-024 STATUS read (addr=1) returns {16'd0, 3'd0, count[4:0], 6'd0, ovf, perr}; count is 0..16.
REQ-025 rd with sel and addr=1 SHALL clear ovf and perr at that edge, unless a new event sets them in the same cycle (set wins).
REQ-026 Push on a full FIFO without a simultaneous pop SHALL drop the byte and set ovf; FIFO contents unchanged.
REQ-027 Simultaneous push and pop on a full FIFO SHALL accept both; count stays 16, ovf unchanged.
REQ-028 Simultaneous push and pop on an empty FIFO: pop ignored, push accepted, count becomes 1.
REQ-029 Read/write pointers are FIFO_AW bits and wrap modulo depth; count is FIFO_AW+1 bits.
REQ-030 data_out SHALL be 32'h0 when sel is low.

Reset
REQ-031 rst asserted SHALL asynchronously force: FSM IDLE, bit counter 0, timeout counter 0, pointers 0, count 0, ovf 0, perr 0, filtered clock 1, synchronizers 1, irq 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first frame after release is decoded normally.

Verification
REQ-033 Send frame for 8'h1C (start 0, bits LSB first, parity 0, stop 1) -> irq rises; DATA read returns 32'h0000_011C; next DATA read returns 32'h0.
REQ-034 Send 8'hF0, 8'h1C back-to-back, then read DATA twice -> 32'h0000_01F0 then 32'h0000_011C; STATUS count goes 2, 1, 0.
REQ-035 Send 8'h1C with parity bit 1 -> no push; STATUS returns 32'h0000_0001; second STATUS read returns 32'h0.
REQ-036 Send 17 frames with no reads -> count 16, ovf set (STATUS 32'h0000_1002); 16 DATA reads return the first 16 bytes in order.
REQ-037 Glitch: ps2_clk low pulse of FILTER_LEN-2 cycles while IDLE -> no state change; stop frame after 4 data bits and wait TIMEOUT+1 cycles -> FSM IDLE, perr set, count 0.
REQ-038 Assert rst during DATA state, release, send 8'h5A -> DATA read returns 32'h0000_015A, count 0 afterwards.
